// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- 8N1 UART transmitter with a valid/ready byte interface.
//
// A byte is accepted when valid_i and ready_o are both high at a rising edge.
// The frame is one low start bit, eight data bits LSB first and one high stop
// bit. Each bit is held for CLKS_PER_BIT clocks. Nothing is queued: a byte
// offered while a frame is in progress is ignored.
//
// Parameters:
//   CLKS_PER_BIT  clk_i cycles per UART bit (integer >= 2)
//
// Ports:
//   clk_i    in   1  clock, all logic on the rising edge
//   rst_i    in   1  synchronous active-high reset, aborts any frame
//   data_i   in   8  byte to transmit, sampled only in the acceptance cycle
//   valid_i  in   1  byte offered on data_i
//   ready_o  out  1  high in IDLE, when a byte can be accepted this cycle
//   tx_o     out  1  registered serial line, idle high
//   busy_o   out  1  high while a frame is in progress (NOT ready_o)
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;    // position inside the current bit period
    logic [2:0]    idx_q;    // data bit currently on the line
    logic [7:0]    shreg_q;  // bit 0 is always the data bit being sent
    logic          tx_q;
    logic          accept;
    logic          bit_end;

    assign accept  = (state_q == IDLE) && valid_i;
    assign bit_end = (state_q != IDLE) && (cnt_q == CNT_MAX);

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && (idx_q == 3'd7)) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: the handshake is a pure function of the state, and the
    // line comes straight from a flop so nothing on the inputs reaches tx_o.
    always_comb begin
        ready_o = (state_q == IDLE);
        busy_o  = (state_q != IDLE);
        tx_o    = tx_q;
    end

    // Datapath: bit-period counter, bit index, shift register and line flop.
    // The line flop is loaded with the value of the bit that starts on the
    // next cycle, so a bit boundary changes tx_o without any extra delay.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    tx_q  <= 1'b1;
                    if (accept) begin
                        shreg_q <= data_i;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        tx_q  <= shreg_q[0];
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            tx_q <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            shreg_q <= shreg_q >> 1;
                            tx_q    <= shreg_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    cnt_q <= '0;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, giving clk_i cycles per UART bit (integer >= 2).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port data_i, input, 8, byte to transmit; sampled only on acceptance.
REQ-005 SHALL have port valid_i, input, 1, byte offered on data_i.
REQ-006 SHALL have port ready_o, output, 1, high when a byte can be accepted this cycle.
REQ-007 SHALL have port tx_o, output, 1, serial line; 8N1 framing; idle high.
REQ-008 SHALL have port busy_o, output, 1, high while a frame is in progress.

Function
REQ-009 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-010 SHALL drive ready_o = 1 only in IDLE, and busy_o = NOT ready_o.
REQ-011 SHALL accept a byte when valid_i = 1 and ready_o = 1 at a rising edge, latching data_i into an 8-bit shift register and entering START.
REQ-012 SHALL ignore data_i and valid_i in all cycles other than the acceptance cycle; nothing is queued.
REQ-013 SHALL drive tx_o = 0 starting the cycle after acceptance, for exactly CLKS_PER_BIT cycles (START).
REQ-014 SHALL then send 8 data bits LSB first, each held exactly CLKS_PER_BIT cycles (DATA), with a 3-bit bit index from 0 to 7.
REQ-015 SHALL then drive tx_o = 1 for exactly CLKS_PER_BIT cycles (STOP), then enter IDLE.
REQ-016 SHALL make each frame exactly 10*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-017 SHALL hold tx_o = 1 in IDLE.
REQ-018 SHALL register tx_o, with no combinational path from data_i or valid_i to tx_o.
REQ-019 SHALL use a bit-period counter of width $clog2(CLKS_PER_BIT). The counter SHALL count 0 to CLKS_PER_BIT-1, wrap to 0 at each bit boundary, and be held at 0 in IDLE.
REQ-020 SHALL allow back-to-back frames. With valid_i held high, the next start bit SHALL begin exactly CLKS_PER_BIT+1 cycles after the previous stop bit began: the stop bit plus one IDLE accept cycle.
REQ-021 SHALL NOT accept a byte when valid_i rises during START, DATA or STOP; ready_o stays 0 until IDLE.

Reset
REQ-022 SHALL, on rst_i = 1 at a rising edge, enter IDLE and set tx_o = 1, ready_o = 1, busy_o = 0, bit counter = 0, bit index = 0, shift register = 0x00.
REQ-023 SHALL abort any frame in progress on reset. tx_o SHALL be 1 from the cycle after rst_i is sampled, and no remaining bits of the aborted byte are sent.
REQ-024 SHALL give rst_i priority over valid_i; a byte offered in a reset cycle is not accepted.

Verification (CLKS_PER_BIT = 4 unless stated)
REQ-025 SHALL verify single byte: valid_i pulse with data_i = 0x55 -> tx_o low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; ready_o low for 40 cycles.
REQ-026 SHALL verify extremes: 0x00 -> tx_o low for 36 consecutive cycles, then stop high; 0xFF -> start low 4 cycles, then high for 36 cycles.
REQ-027 SHALL verify back-to-back: valid_i held high with 0xA5 then 0x3C -> two correct frames, with 5 high cycles between stop-bit start and the second start bit, and no dropped or duplicated byte.
REQ-028 SHALL verify busy rejection and latching: valid_i = 1 with 0xFF during DATA of 0x12, and data_i changed after acceptance -> frame carries 0x12 only; no second frame.
REQ-029 SHALL verify mid-frame reset: rst_i for 1 cycle during bit 3 of 0x0F -> tx_o = 1 and ready_o = 1 the next cycle; a new byte 0x81 is then sent correctly.
REQ-030 SHALL verify default parameter: CLKS_PER_BIT = 104, byte 0xC3 -> every bit period measures exactly 104 cycles; frame is 1040 cycles.
